vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Timing master for the 640x480@60 VGA display path. Divides the system clock down to a pixel
//  strobe, runs horizontal/vertical counters over the full frame (visible + blanking), drives
//  hsync/vsync to the connector, and drives x, y, video_on to the pixel/game logic.
//  The pixel logic depends on x/y sweeping blanking: its once-per-frame update fires at y==481, x==0.
// PARAMETERS
//  CLK_DIV    4    clk cycles per pixel (100 MHz -> 25 MHz); legal range >= 1
//  H_DISPLAY  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, in pixels
//  H_SYNC     96   hsync pulse width, in pixels
//  H_BACK     48   horizontal back porch; H_TOTAL = sum of the four H_* = 800
//  V_DISPLAY  480  visible lines per frame
//  V_FRONT    10   vertical front porch, in lines
//  V_SYNC     2    vsync pulse width, in lines
//  V_BACK     33   vertical back porch; V_TOTAL = sum of the four V_* = 525
// PORTS
//  clk         in   1   system clock; the only clock in the block
//  reset       in   1   synchronous, active-high
//  p_tick      out  1   one-clk pulse per pixel period; all counters advance only on p_tick
//  x           out  10  horizontal counter, 0..H_TOTAL-1
//  y           out  10  vertical counter, 0..V_TOTAL-1
//  video_on    out  1   1 when x<H_DISPLAY && y<V_DISPLAY (combinational from x, y)
//  hsync       out  1   active-low, registered
//  vsync       out  1   active-low, registered
//  line_tick   out  1   1 when p_tick && x==H_TOTAL-1
//  frame_tick  out  1   1 when p_tick && x==H_TOTAL-1 && y==V_TOTAL-1
// BEHAVIOUR
//  Reset values (at the clk edge where reset=1):
//   - div_cnt=0, x=0, y=0, hsync=1, vsync=1
//   - p_tick=0, line_tick=0, frame_tick=0
//   - video_on=1, because it follows x=0, y=0
//  Reset taken mid-frame: the same values at the next edge; no partial-line recovery.
//  Divider:
//   - div_cnt counts 0..CLK_DIV-1 and wraps.
//   - p_tick = (div_cnt==CLK_DIV-1) && !reset.
//   - CLK_DIV=1: p_tick is high every cycle not in reset.
//  Counters: registered, updated only on cycles with p_tick=1.
//   - x: x_next = (x==H_TOTAL-1) ? 0 : x+1
//   - y: changes only when x wraps; y_next = (y==V_TOTAL-1) ? 0 : y+1
//   - Both wrap on the same edge at end of frame.
//  Sync outputs: registered from x_next/y_next on the p_tick edge, so they are cycle-aligned with x/y.
//   - hsync=0 for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751
//   - vsync=0 for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491
//   - High elsewhere.
//  Widths:
//   - x/y/counters are 10 bits; H_TOTAL and V_TOTAL must not exceed 1024.
//   - div_cnt is $clog2(CLK_DIV) bits, minimum 1.
//  No glitches: x, y, hsync and vsync are flop outputs and change only on p_tick edges.
//  Frame period: H_TOTAL*V_TOTAL*CLK_DIV clk cycles, i.e. 1,680,000 at the defaults.
// TESTING
//  T1 reset, then release:
//   - p_tick first rises in the 4th clk after release
//   - x becomes 1 on the edge closing that cycle
//   - hsync=vsync=1, video_on=1 throughout
//  T2 run one line:
//   - hsync falls exactly when x becomes 656 and rises when x becomes 752 (96*4=384 clk low)
//   - video_on drops when x becomes 640
//   - line_tick pulses once, at x=799
//  T3 run one full frame:
//   - vsync low only for y=490..491 (1600 pixels)
//   - frame_tick pulses once, at x=799, y=524
//   - x and y both read 0 on the next p_tick edge
//   - 1,680,000 clk between consecutive frame_ticks
//  T4 pixel-logic hook: the refresh condition y==481 && x==0 is true for exactly CLK_DIV clk per frame.
//  T5 assert reset for 1 clk at x=700, y=300 (inside hsync low):
//   - next edge: x=0, y=0, hsync=1, div_cnt=0
//   - timing then restarts as in T1
//  T6 re-run T2 and T3 with CLK_DIV=1:
//   - p_tick high continuously
//   - 420,000 clk per frame
//   - identical sync positions

Source files
------------

// File: rtl/vga_sync_gen.sv
// Timing master for a VGA display path: pixel-strobe divider, horizontal/vertical
// counters over the whole frame, registered active-low syncs and line/frame ticks.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick;
    logic             x_end;
    logic             y_end;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST) && !reset;
        x_end     = (x_q == X_LAST);
        y_end     = (y_q == Y_LAST);
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        x_d       = x_q;
        y_d       = y_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        if (tick) begin
            x_d = x_end ? 10'd0 : x_q + 10'd1;
            if (x_end) begin
                y_d = y_end ? 10'd0 : y_q + 10'd1;
            end
            // Syncs decode the next counter values so they stay aligned with x/y.
            hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
            vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign p_tick     = tick;
    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign line_tick  = tick && x_end;
    assign frame_tick = tick && x_end && y_end;
    assign video_on   = (x_q < X_VIS) && (y_q < Y_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four instances (default timing at two dividers, a reduced
// frame at two dividers) checked against a scoreboard of expected output events.
module tb_vga_sync_gen;

    localparam int N = 4;
    localparam int CD [N] = '{4, 1, 3, 1};
    localparam int HD [N] = '{640, 640, 8, 8};
    localparam int HF [N] = '{16, 16, 2, 2};
    localparam int HS [N] = '{96, 96, 3, 3};
    localparam int HB [N] = '{48, 48, 2, 2};
    localparam int VD [N] = '{480, 480, 6, 6};
    localparam int VF [N] = '{10, 10, 2, 2};
    localparam int VS [N] = '{2, 2, 2, 2};
    localparam int VB [N] = '{33, 33, 1, 1};

    localparam int EV_VID_ON  = 0;
    localparam int EV_VID_OFF = 1;
    localparam int EV_HS_FALL = 2;
    localparam int EV_HS_RISE = 3;
    localparam int EV_VS_FALL = 4;
    localparam int EV_VS_RISE = 5;
    localparam int EV_LINE    = 6;
    localparam int EV_FRAME   = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0]      p_tick_s, video_on_s, hsync_s, vsync_s, line_tick_s, frame_tick_s;
    logic [N-1:0][9:0] x_s, y_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int k;
        int x;
        int y;
    } ev_t;
    ev_t exp_q [$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            vga_sync_gen #(
                .CLK_DIV  (CD[gi]),
                .H_DISPLAY(HD[gi]),
                .H_FRONT  (HF[gi]),
                .H_SYNC   (HS[gi]),
                .H_BACK   (HB[gi]),
                .V_DISPLAY(VD[gi]),
                .V_FRONT  (VF[gi]),
                .V_SYNC   (VS[gi]),
                .V_BACK   (VB[gi])
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .p_tick    (p_tick_s[gi]),
                .x         (x_s[gi]),
                .y         (y_s[gi]),
                .video_on  (video_on_s[gi]),
                .hsync     (hsync_s[gi]),
                .vsync     (vsync_s[gi]),
                .line_tick (line_tick_s[gi]),
                .frame_tick(frame_tick_s[gi])
            );
        end
    endgenerate

    function automatic string kname(input int kind);
        case (kind)
            EV_VID_ON:  return "vid_on";
            EV_VID_OFF: return "vid_off";
            EV_HS_FALL: return "hs_fall";
            EV_HS_RISE: return "hs_rise";
            EV_VS_FALL: return "vs_fall";
            EV_VS_RISE: return "vs_rise";
            EV_LINE:    return "line";
            default:    return "frame";
        endcase
    endfunction

    // Tasks start and end at negedge+2 so outputs are sampled mid-cycle.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Hold reset across one rising edge; k=0 state is visible on return.
    task automatic do_reset(input bit check);
        logic [23:0] got;
        reset = 1'b1;
        @(negedge clk);
        #1;
        if (check) begin
            for (int i = 0; i < N; i++) begin
                got = {x_s[i], y_s[i], hsync_s[i], vsync_s[i], p_tick_s[i],
                       video_on_s[i], line_tick_s[i], frame_tick_s[i]};
                checks++;
                if (got !== {10'd0, 10'd0, 6'b110100}) begin
                    errors++;
                    $display("FAIL reset_values dut%0d: got %h required %h", i, got,
                             {10'd0, 10'd0, 6'b110100});
                end else begin
                    $display("ok   reset_values dut%0d", i);
                end
            end
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic push(input int kind, input int k, input int x, input int y);
        ev_t e;
        e.kind = kind;
        e.k    = k;
        e.x    = x;
        e.y    = y;
        exp_q.push_back(e);
    endtask

    // Expected events from the frame geometry: pixel P is visible after edge P*CLK_DIV,
    // and the line tick is high in the last clk of pixel H_TOTAL-1.
    task automatic push_events(input int idx, input int nlines);
        int d, ht, vt, yy, base;
        d  = CD[idx];
        ht = HD[idx] + HF[idx] + HS[idx] + HB[idx];
        vt = VD[idx] + VF[idx] + VS[idx] + VB[idx];
        for (int l = 0; l <= nlines; l++) begin
            yy   = l % vt;
            base = l * ht;
            if (l > 0) begin
                if (yy < VD[idx]) push(EV_VID_ON, base * d, 0, yy);
                if (yy == VD[idx] + VF[idx]) push(EV_VS_FALL, base * d, 0, yy);
                if (yy == VD[idx] + VF[idx] + VS[idx]) push(EV_VS_RISE, base * d, 0, yy);
            end
            if (l < nlines) begin
                if (yy < VD[idx]) push(EV_VID_OFF, (base + HD[idx]) * d, HD[idx], yy);
                push(EV_HS_FALL, (base + HD[idx] + HF[idx]) * d, HD[idx] + HF[idx], yy);
                push(EV_HS_RISE, (base + HD[idx] + HF[idx] + HS[idx]) * d,
                     HD[idx] + HF[idx] + HS[idx], yy);
                push(EV_LINE, (base + ht - 1) * d + d - 1, ht - 1, yy);
                if (yy == vt - 1) push(EV_FRAME, (base + ht - 1) * d + d - 1, ht - 1, yy);
            end
        end
    endtask

    task automatic got_event(input int idx, input int kind, input int k, input int x,
                             input int y);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event dut%0d: got %s k=%0d x=%0d y=%0d, required no event",
                     idx, kname(kind), k, x, y);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.k != k || e.x != x || e.y != y) begin
                errors++;
                $display("FAIL event dut%0d: got %s k=%0d x=%0d y=%0d, required %s k=%0d x=%0d y=%0d",
                         idx, kname(kind), k, x, y, kname(e.kind), e.k, e.x, e.y);
            end else begin
                $display("ok   event dut%0d: %s k=%0d x=%0d y=%0d", idx, kname(kind), k, x, y);
            end
        end
    endtask

    // Run nlines lines from the k=0 state, matching output transitions to the scoreboard.
    task automatic run_check(input int idx, input int nlines);
        int d, ht, vt, total, refresh, exp_refresh;
        logic pv_vo, pv_hs, pv_vs;
        d  = CD[idx];
        ht = HD[idx] + HF[idx] + HS[idx] + HB[idx];
        vt = VD[idx] + VF[idx] + VS[idx] + VB[idx];
        total = nlines * ht * d;
        exp_q.delete();
        push_events(idx, nlines);
        pv_vo = video_on_s[idx];
        pv_hs = hsync_s[idx];
        pv_vs = vsync_s[idx];
        refresh = 0;
        for (int k = 1; k <= total; k++) begin
            step();
            if (video_on_s[idx] !== pv_vo)
                got_event(idx, video_on_s[idx] ? EV_VID_ON : EV_VID_OFF, k, x_s[idx], y_s[idx]);
            if (hsync_s[idx] !== pv_hs)
                got_event(idx, hsync_s[idx] ? EV_HS_RISE : EV_HS_FALL, k, x_s[idx], y_s[idx]);
            if (vsync_s[idx] !== pv_vs)
                got_event(idx, vsync_s[idx] ? EV_VS_RISE : EV_VS_FALL, k, x_s[idx], y_s[idx]);
            if (line_tick_s[idx] === 1'b1) got_event(idx, EV_LINE, k, x_s[idx], y_s[idx]);
            if (frame_tick_s[idx] === 1'b1) got_event(idx, EV_FRAME, k, x_s[idx], y_s[idx]);
            if (x_s[idx] == 10'd0 && int'(y_s[idx]) == VD[idx] + 1) refresh++;
            pv_vo = video_on_s[idx];
            pv_hs = hsync_s[idx];
            pv_vs = vsync_s[idx];
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events dut%0d: got %0d unmatched, required 0 (next %s k=%0d)",
                     idx, exp_q.size(), kname(exp_q[0].kind), exp_q[0].k);
        end else begin
            $display("ok   all_events_seen dut%0d lines=%0d", idx, nlines);
        end
        exp_refresh = (nlines % vt == VD[idx] + 1) ? 1 : 0;
        for (int l = 1; l < nlines; l++) begin
            if (l % vt == VD[idx] + 1) exp_refresh += d;
        end
        checks++;
        if (refresh != exp_refresh) begin
            errors++;
            $display("FAIL refresh_cycles dut%0d: got %0d required %0d", idx, refresh, exp_refresh);
        end else begin
            $display("ok   refresh_cycles dut%0d = %0d", idx, refresh);
        end
    endtask

    task automatic test_reset();
        logic [3:0] got;
        do_reset(1'b1);
        checks++;
        if (p_tick_s[1] !== 1'b1) begin
            errors++;
            $display("FAIL ptick_div1_first dut1: got %b required 1", p_tick_s[1]);
        end else begin
            $display("ok   ptick_div1_first dut1");
        end
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) step();
            got = {p_tick_s[0], hsync_s[0], vsync_s[0], video_on_s[0]};
            checks++;
            if (got !== {(k == 3), 3'b111} || x_s[0] !== 10'(k / 4)) begin
                errors++;
                $display("FAIL release k=%0d dut0: got ptick/hs/vs/vo=%b x=%0d required %b x=%0d",
                         k, got, x_s[0], {(k == 3), 3'b111}, k / 4);
            end else begin
                $display("ok   release k=%0d dut0 ptick=%b x=%0d", k, p_tick_s[0], x_s[0]);
            end
        end
    endtask

    task automatic test_line();
        do_reset(1'b0);
        run_check(0, 2);
        do_reset(1'b0);
        run_check(1, 2);
    endtask

    task automatic test_frame();
        do_reset(1'b0);
        run_check(2, 22);
        do_reset(1'b0);
        run_check(3, 22);
    endtask

    task automatic test_reset_mid(input int idx, input int cycles, input int xr, input int yr);
        logic [21:0] got;
        do_reset(1'b0);
        for (int k = 0; k < cycles; k++) step();
        checks++;
        if (int'(x_s[idx]) != xr || int'(y_s[idx]) != yr || hsync_s[idx] !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup dut%0d: got x=%0d y=%0d hs=%b required x=%0d y=%0d hs=0",
                     idx, x_s[idx], y_s[idx], hsync_s[idx], xr, yr);
        end else begin
            $display("ok   mid_setup dut%0d x=%0d y=%0d", idx, xr, yr);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        got = {x_s[idx], y_s[idx], hsync_s[idx], vsync_s[idx]};
        checks++;
        if (got !== {10'd0, 10'd0, 2'b11}) begin
            errors++;
            $display("FAIL mid_reset dut%0d: got %h required %h", idx, got, {10'd0, 10'd0, 2'b11});
        end else begin
            $display("ok   mid_reset dut%0d", idx);
        end
        reset = 1'b0;
        #1;
        run_check(idx, (idx == 0) ? 1 : 11);
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_reset_mid(0, 2801, 700, 0);
        test_reset_mid(2, 169, 11, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
